// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter: round-robin arbiter granting one of two requester AXI streams onto the PCIe TX stream, packet-atomic
module pcie_tx_arbiter #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic                    user_lnk_up,
    input  logic                    req0,
    input  logic                    req1,
    output logic                    ack0,
    output logic                    ack1,
    input  logic [C_DATA_WIDTH-1:0] s0_tdata,
    input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
    input  logic [3:0]              s0_tuser,
    input  logic                    s0_tlast,
    input  logic                    s0_tvalid,
    output logic                    s0_tready,
    input  logic [C_DATA_WIDTH-1:0] s1_tdata,
    input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
    input  logic [3:0]              s1_tuser,
    input  logic                    s1_tlast,
    input  logic                    s1_tvalid,
    output logic                    s1_tready,
    output logic [C_DATA_WIDTH-1:0] s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   s_axis_tx_tkeep,
    output logic [3:0]              s_axis_tx_tuser,
    output logic                    s_axis_tx_tlast,
    output logic                    s_axis_tx_tvalid,
    input  logic                    s_axis_tx_tready,
    output logic [31:0]             pkt_cnt0,
    output logic [31:0]             pkt_cnt1
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t      state_q, state_d;
    logic        lw_q, lw_d;
    logic        in_pkt_q, in_pkt_d;
    logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [31:0] pkt_cnt1_q, pkt_cnt1_d;
    logic        beat;
    logic        last;

    assign ack0     = state_q == GNT0;
    assign ack1     = state_q == GNT1;
    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
    assign beat     = s_axis_tx_tvalid & s_axis_tx_tready;
    assign last     = beat & s_axis_tx_tlast;

    // Route the granted requester onto the TX stream; everything is quiet while idle
    always_comb begin
        s_axis_tx_tdata  = '0;
        s_axis_tx_tkeep  = '0;
        s_axis_tx_tuser  = '0;
        s_axis_tx_tlast  = 1'b0;
        s_axis_tx_tvalid = 1'b0;
        s0_tready        = 1'b0;
        s1_tready        = 1'b0;
        if (state_q == GNT0) begin
            s_axis_tx_tdata  = s0_tdata;
            s_axis_tx_tkeep  = s0_tkeep;
            s_axis_tx_tuser  = s0_tuser;
            s_axis_tx_tlast  = s0_tlast;
            s_axis_tx_tvalid = s0_tvalid;
            s0_tready        = s_axis_tx_tready;
        end else if (state_q == GNT1) begin
            s_axis_tx_tdata  = s1_tdata;
            s_axis_tx_tkeep  = s1_tkeep;
            s_axis_tx_tuser  = s1_tuser;
            s_axis_tx_tlast  = s1_tlast;
            s_axis_tx_tvalid = s1_tvalid;
            s1_tready        = s_axis_tx_tready;
        end
    end

    // Arbitration, packet tracking and completion counting
    always_comb begin
        state_d    = state_q;
        lw_d       = lw_q;
        in_pkt_d   = beat ? !s_axis_tx_tlast : in_pkt_q;
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        case (state_q)
            IDLE: begin
                if (user_lnk_up) begin
                    if (req0 && req1) state_d = lw_q ? GNT0 : GNT1;
                    else if (req0)    state_d = GNT0;
                    else if (req1)    state_d = GNT1;
                end
            end
            GNT0: begin
                if (last) begin
                    state_d    = IDLE;
                    lw_d       = 1'b0;
                    pkt_cnt0_d = pkt_cnt0_q + 32'd1;
                end else if (!req0 && !in_pkt_q && !beat) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (last) begin
                    state_d    = IDLE;
                    lw_d       = 1'b1;
                    pkt_cnt1_d = pkt_cnt1_q + 32'd1;
                end else if (!req1 && !in_pkt_q && !beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; last-winner resets to 1 so requester 0 takes the first tie
    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            state_q    <= IDLE;
            lw_q       <= 1'b1;
            in_pkt_q   <= 1'b0;
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            state_q    <= state_d;
            lw_q       <= lw_d;
            in_pkt_q   <= in_pkt_d;
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end
endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb_pcie_tx_arbiter: directed scenario bench for pcie_tx_arbiter
module tb_pcie_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, lnk, req0, req1, ack0, ack1, txr;
    logic [63:0] s0_tdata, s1_tdata, tx_tdata;
    logic [7:0]  s0_tkeep, s1_tkeep, tx_tkeep;
    logic [3:0]  s0_tuser, s1_tuser, tx_tuser;
    logic        s0_tlast, s0_tvalid, s0_tready, s1_tlast, s1_tvalid, s1_tready;
    logic        tx_tlast, tx_tvalid;
    logic [31:0] pkt_cnt0, pkt_cnt1;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    pcie_tx_arbiter #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8)) dut (
        .user_clk(clk), .user_reset_n(rst_n), .user_lnk_up(lnk),
        .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser),
        .s0_tlast(s0_tlast), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser),
        .s1_tlast(s1_tlast), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .s_axis_tx_tdata(tx_tdata), .s_axis_tx_tkeep(tx_tkeep), .s_axis_tx_tuser(tx_tuser),
        .s_axis_tx_tlast(tx_tlast), .s_axis_tx_tvalid(tx_tvalid), .s_axis_tx_tready(txr),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req0 = 0; req1 = 0; txr = 1;
        s0_tdata = '0; s0_tkeep = '0; s0_tuser = '0; s0_tlast = 0; s0_tvalid = 0;
        s1_tdata = '0; s1_tkeep = '0; s1_tuser = '0; s1_tlast = 0; s1_tvalid = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        quiet();
        step();
        step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        lnk = 1;
        do_reset();
        rst_n = 0;
        s0_tvalid = 1; s0_tlast = 1; s0_tdata = 64'hDEAD; s1_tvalid = 1;
        #1;
        tests++;
        if ({ack0, ack1, tx_tvalid, tx_tlast, s0_tready, s1_tready} !== 6'b0) begin
            $display("FAIL reset_ctrl got %b want 000000", {ack0, ack1, tx_tvalid, tx_tlast, s0_tready, s1_tready}); fails++;
        end
        tests++;
        if ({tx_tdata, tx_tkeep, tx_tuser} !== 76'b0) begin
            $display("FAIL reset_data got %h want 0", {tx_tdata, tx_tkeep, tx_tuser}); fails++;
        end
        tests++;
        if (pkt_cnt0 !== 0 || pkt_cnt1 !== 0) begin
            $display("FAIL reset_cnt got %0d/%0d want 0/0", pkt_cnt0, pkt_cnt1); fails++;
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [63:0] d [3];
        d[0] = 64'h1111_2222_3333_4444; d[1] = 64'h5555_6666_7777_8888; d[2] = 64'h99AA_BBCC_DDEE_FF00;
        do_reset();
        lnk = 1; req0 = 1;
        step();
        tests++;
        if (ack0 !== 1 || ack1 !== 0) begin
            $display("FAIL single_ack got %b%b want 10", ack0, ack1); fails++;
        end
        for (int k = 0; k < 3; k++) begin
            s0_tdata = d[k]; s0_tkeep = (k == 2) ? 8'h0F : 8'hFF; s0_tuser = 4'h5;
            s0_tlast = (k == 2); s0_tvalid = 1;
            if (k == 2) req0 = 0;
            #1;
            tests++;
            if (tx_tdata !== d[k] || tx_tkeep !== s0_tkeep || tx_tuser !== 4'h5 || tx_tlast !== (k == 2) ||
                tx_tvalid !== 1 || s0_tready !== 1 || s1_tready !== 0) begin
                $display("FAIL single_beat%0d got %h/%h/%h/%b/%b/%b/%b want %h/%h/5/%b/1/1/0", k, tx_tdata, tx_tkeep,
                         tx_tuser, tx_tlast, tx_tvalid, s0_tready, s1_tready, d[k], s0_tkeep, k == 2); fails++;
            end
            step();
        end
        s0_tvalid = 0; s0_tlast = 0;
        tests++;
        if (ack0 !== 0 || pkt_cnt0 !== 1 || tx_tvalid !== 0) begin
            $display("FAIL single_done got ack0=%b cnt0=%0d tvalid=%b want 0/1/0", ack0, pkt_cnt0, tx_tvalid); fails++;
        end
    endtask

    task automatic test_tie();
        int exp [12] = '{1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2, 0};
        logic b0, b1, a0, a1;
        do_reset();
        lnk = 1; req0 = 1; req1 = 1; b0 = 0; b1 = 0;
        s0_tvalid = 1; s1_tvalid = 1; s0_tlast = 0; s1_tlast = 0;
        step();
        for (int i = 0; i < 12; i++) begin
            tests++;
            if (ack0 !== (exp[i] == 1) || ack1 !== (exp[i] == 2)) begin
                $display("FAIL tie_cyc%0d got ack=%b%b want grant %0d", i, ack0, ack1, exp[i]); fails++;
            end
            a0 = ack0; a1 = ack1;
            if (i == 11) quiet();
            step();
            if (a0) b0 = ~b0;
            if (a1) b1 = ~b1;
            if (i != 11) begin s0_tlast = b0; s1_tlast = b1; end
        end
        tests++;
        if (ack0 !== 0 || ack1 !== 0 || pkt_cnt0 !== 2 || pkt_cnt1 !== 2) begin
            $display("FAIL tie_end got ack=%b%b cnt=%0d/%0d want 00 2/2", ack0, ack1, pkt_cnt0, pkt_cnt1); fails++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d [3];
        logic        tr [5] = '{1, 0, 0, 1, 1};
        logic [63:0] got [$];
        int          k = 0;
        d[0] = 64'hA0; d[1] = 64'hA1; d[2] = 64'hA2;
        do_reset();
        lnk = 1; req1 = 1;
        s0_tvalid = 1; s0_tdata = 64'hBAD; s0_tlast = 1;
        step();
        for (int c = 0; c < 5; c++) begin
            txr = tr[c];
            s1_tvalid = 1; s1_tdata = d[k]; s1_tkeep = 8'hFF; s1_tlast = (k == 2);
            #1;
            tests++;
            if (s1_tready !== tr[c] || s0_tready !== 0 || tx_tdata !== d[k] || ack1 !== 1) begin
                $display("FAIL bp_cyc%0d got s1r=%b s0r=%b data=%h ack1=%b want %b/0/%h/1", c, s1_tready, s0_tready,
                         tx_tdata, ack1, tr[c], d[k]); fails++;
            end
            if (tx_tvalid && txr) begin got.push_back(tx_tdata); k++; req1 = 0; end
            step();
        end
        quiet();
        tests++;
        if (got.size() != 3 || got[0] !== d[0] || got[1] !== d[1] || got[2] !== d[2]) begin
            $display("FAIL bp_beats got %0d beats want A0,A1,A2", got.size()); fails++;
        end
        tests++;
        if (ack1 !== 0 || pkt_cnt1 !== 1 || pkt_cnt0 !== 0) begin
            $display("FAIL bp_done got ack1=%b cnt=%0d/%0d want 0 0/1", ack1, pkt_cnt0, pkt_cnt1); fails++;
        end
    endtask

    task automatic test_link();
        do_reset();
        lnk = 0; req0 = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            tests++;
            if (ack0 !== 0) begin $display("FAIL link_down_cyc%0d got ack0=%b want 0", c, ack0); fails++; end
        end
        lnk = 1;
        step();
        tests++;
        if (ack0 !== 1) begin $display("FAIL link_up got ack0=%b want 1", ack0); fails++; end
        req0 = 0;
        step();
        tests++;
        if (ack0 !== 0 || pkt_cnt0 !== 0) begin
            $display("FAIL abandon got ack0=%b cnt0=%0d want 0/0", ack0, pkt_cnt0); fails++;
        end
        req0 = 1;
        step();
        s0_tvalid = 1; s0_tlast = 0; lnk = 0;
        step();
        tests++;
        if (ack0 !== 1) begin $display("FAIL link_mid got ack0=%b want 1", ack0); fails++; end
        s0_tlast = 1; req0 = 0;
        step();
        quiet();
        tests++;
        if (ack0 !== 0 || pkt_cnt0 !== 1) begin
            $display("FAIL link_done got ack0=%b cnt0=%0d want 0/1", ack0, pkt_cnt0); fails++;
        end
        lnk = 1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        lnk = 1; req0 = 1;
        step();
        s0_tvalid = 1; s0_tlast = 1;
        step();
        s0_tvalid = 0;
        tests++;
        if (ack0 !== 0 || pkt_cnt0 !== 1) begin
            $display("FAIL b2b_gap got ack0=%b cnt0=%0d want 0/1", ack0, pkt_cnt0); fails++;
        end
        step();
        tests++;
        if (ack0 !== 1) begin $display("FAIL b2b_regrant got ack0=%b want 1", ack0); fails++; end
        req1 = 1; s0_tvalid = 1;
        step();
        s0_tvalid = 0;
        step();
        tests++;
        if (ack0 !== 0 || ack1 !== 1) begin
            $display("FAIL b2b_other got ack=%b%b want 01", ack0, ack1); fails++;
        end
        quiet();
        step();
    endtask

    task automatic test_wrap_reset();
        do_reset();
        lnk = 1;
        force dut.pkt_cnt1_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt1_q;
        tests++;
        if (pkt_cnt1 !== 32'hFFFF_FFFF) begin
            $display("FAIL wrap_preload got %h want ffffffff", pkt_cnt1); fails++;
        end
        req1 = 1;
        step();
        s1_tvalid = 1; s1_tlast = 1; req1 = 0;
        step();
        quiet();
        tests++;
        if (pkt_cnt1 !== 0 || ack1 !== 0) begin
            $display("FAIL wrap got cnt1=%h ack1=%b want 0/0", pkt_cnt1, ack1); fails++;
        end
        req0 = 1;
        step();
        s0_tvalid = 1; s0_tlast = 0;
        step();
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (ack0 !== 0 || tx_tvalid !== 0 || s0_tready !== 0) begin
            $display("FAIL reset_mid got ack0=%b tvalid=%b s0r=%b want 000", ack0, tx_tvalid, s0_tready); fails++;
        end
        quiet();
        step();
        rst_n = 1;
        step();
        tests++;
        if (ack0 !== 0 || ack1 !== 0 || pkt_cnt0 !== 0) begin
            $display("FAIL reset_after got ack=%b%b cnt0=%0d want 00 0", ack0, ack1, pkt_cnt0); fails++;
        end
    endtask

    initial begin
        rst_n = 0;
        lnk = 0;
        quiet();
        test_reset();
        test_single();
        test_tie();
        test_backpressure();
        test_link();
        test_back_to_back();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pcie_tx_arbiter.md
PCIE_TX_ARBITER -- requirements
Module: pcie_tx_arbiter

Interface
REQ-001 SHALL have parameter C_DATA_WIDTH, default 64, TX AXI-Stream data width.
REQ-002 SHALL have parameter KEEP_WIDTH, default C_DATA_WIDTH/8, byte-enable width.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset, named as in the interface list below.
REQ-004 SHALL have port user_clk, input, 1, sole clock; all logic is rising-edge.
REQ-005 SHALL have port user_reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port user_lnk_up, input, 1, PCIe link up.
REQ-007 SHALL have ports req0/req1, input, 1 each, per-requester TX access request.
REQ-008 SHALL have ports ack0/ack1, output, 1 each, per-requester grant.
REQ-009 SHALL have ports sN_tdata [C_DATA_WIDTH], sN_tkeep [KEEP_WIDTH], sN_tuser [4], sN_tlast, sN_tvalid (inputs) and sN_tready (output) for N=0,1: requester streams.
REQ-010 SHALL have ports s_axis_tx_tdata, s_axis_tx_tkeep, s_axis_tx_tuser [4], s_axis_tx_tlast, s_axis_tx_tvalid (outputs) and s_axis_tx_tready (input): PCIe core TX stream.
REQ-011 SHALL have ports pkt_cnt0/pkt_cnt1, output, 32 each, completed-packet counters.

Function
REQ-012 SHALL implement states IDLE, GNT0, GNT1 in a registered state machine.
REQ-013 SHALL keep a registered last-winner bit (0 or 1) for round-robin priority.
REQ-014 In IDLE with user_lnk_up=1: the FSM SHALL go to GNT0 if only req0, to GNT1 if only req1, or to the requester not equal to last-winner if both assert.
REQ-015 In IDLE with user_lnk_up=0: the FSM SHALL stay in IDLE regardless of req.
REQ-016 ackN SHALL be 1 exactly while the state is GNTN (registered output); latency from req to ack is 1 cycle when IDLE and uncontended.
REQ-017 In GNTN: s_axis_tx_* SHALL equal the sN_* fields, s_axis_tx_tvalid SHALL equal sN_tvalid, sN_tready SHALL equal s_axis_tx_tready, and the other requester's tready SHALL be 0 (combinational mux).
REQ-018 In IDLE: s_axis_tx_tvalid, s_axis_tx_tlast, s0_tready and s1_tready SHALL be 0; data, keep and user SHALL be 0.
REQ-019 SHALL keep an in_pkt flag that sets on an accepted non-last beat (tvalid&tready&!tlast) and clears on an accepted last beat.
REQ-020 In GNTN, an accepted beat with tlast=1 SHALL move the FSM to IDLE, set last-winner=N and increment pkt_cntN; ack drops on the next cycle.
REQ-021 In GNTN, if reqN=0 and in_pkt=0 and no beat is accepted that cycle, the FSM SHALL return to IDLE without counting and without updating last-winner.
REQ-022 reqN=0 while in_pkt=1 SHALL be ignored; the grant holds until tlast.
REQ-023 user_lnk_up falling during GNTN SHALL NOT revoke the grant; no packet is truncated.
REQ-024 A single-beat packet (tlast on the first beat) SHALL complete per REQ-020.
REQ-025 A back-to-back request by the same requester SHALL pass through one IDLE cycle; if the other requester is waiting, it wins.
REQ-026 pkt_cntN SHALL be 32-bit and wrap from 0xFFFFFFFF to 0.

Reset
REQ-027 While user_reset_n=0 (asynchronously): state=IDLE, last-winner=1 (so requester 0 wins the first tie), in_pkt=0, ack0=ack1=0, pkt_cnt0=pkt_cnt1=0, and all outputs per REQ-018.
REQ-028 Reset asserted mid-packet SHALL abort the packet immediately; after deassertion, arbitration restarts from IDLE with no grant carried over.

Verification
REQ-029 Single requester: req0=1 with link up, 3-beat packet, tready=1 -> ack0 at cycle+1, 3 beats pass unmodified, ack0=0 after tlast, pkt_cnt0=1.
REQ-030 Tie: req0=req1=1 from reset, both sending 2-beat packets continuously -> grants go 0,1,0,1; each grant is separated by one IDLE cycle; counters are equal.
REQ-031 Backpressure: tready toggles 1,0,0,1 during a GNT1 packet -> s1_tready mirrors it, no beat is duplicated or lost, s0_tready=0 throughout.
REQ-032 Link and abandon: req0 with link down -> no ack; link up then req0 drops before the first beat -> back to IDLE, pkt_cnt0 unchanged; link down mid-packet -> packet completes.
REQ-033 Reset and wrap: pkt_cnt1 preloaded via 2^32-1 packets (or force) plus 1 more -> pkt_cnt1=0; reset asserted mid-packet -> ack=0 and tvalid=0 immediately.
